// File: rtl/bank_xbar_resp.sv
// bank_xbar_resp: bank-side endpoint that queues crossbar requests, drives the data array and returns tagged read data.
// Optional macro BANK_XBAR_RESP_BYPASS_EN: an issuable request arriving at an empty request FIFO goes to the array in its accept cycle.
module bank_xbar_resp #(
  parameter int REQ_DEPTH = 4,
  parameter int RTN_DEPTH = 4,
  parameter int RD_LAT    = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         xbar_bank_htu_valid_i,
  output logic         xbar_bank_htu_allowIn_o,
  input  logic [1:0]   xbar_bank_htu_ch_id_i,
  input  logic [1:0]   xbar_bank_htu_opcode_i,
  input  logic [27:0]  xbar_bank_htu_addr_i,
  input  logic [7:0]   xbar_bank_htu_wbuffer_id_i,
  output logic         arr_rd_valid_o,
  output logic [27:0]  arr_rd_addr_o,
  input  logic [127:0] arr_rd_data_i,
  output logic         arr_wr_valid_o,
  output logic [27:0]  arr_wr_addr_o,
  output logic [7:0]   arr_wr_wbuffer_id_o,
  output logic         bank_sc_xbar_valid_o,
  input  logic         bank_sc_xbar_allowIn_i,
  output logic [1:0]   bank_sc_xbar_ch_id_o,
  output logic [2:0]   bank_sc_xbar_rob_num_o,
  output logic [127:0] bank_sc_xbar_data_o
);
  localparam int RAW = $clog2(REQ_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int TAW = $clog2(RTN_DEPTH);
  localparam int TCW = TAW + 1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  ch;
    logic [2:0]  rob;
    logic [27:0] addr;
    logic [7:0]  wbid;
  } req_t;

  typedef struct packed {
    logic [1:0]   ch;
    logic [2:0]   rob;
    logic [127:0] data;
  } rtn_t;

  req_t           req_mem_q [REQ_DEPTH];
  logic [RAW-1:0] req_wp_q, req_rp_q;
  logic [RCW-1:0] req_cnt_q, req_cnt_d;
  logic           allow_q;
  logic [2:0]     seq_q [4];
  logic [TCW-1:0] inflight_q, inflight_d;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [1:0]     pipe_ch_q  [RD_LAT];
  logic [2:0]     pipe_rob_q [RD_LAT];
  rtn_t           rtn_mem_q [RTN_DEPTH];
  logic [TAW-1:0] rtn_wp_q, rtn_rp_q;
  logic [TCW-1:0] rtn_cnt_q, rtn_cnt_d;

  req_t in_req_s, head_s, iss_s;
  rtn_t rtn_head_s;
  logic accept_s, credit_s, iss_vld_s, bypass_s, push_s, pop_s;
  logic rd_iss_s, wr_iss_s, pipe_last_s, rtn_vld_s, rtn_pop_s;

  assign accept_s = xbar_bank_htu_valid_i && allow_q;
  assign in_req_s = {(xbar_bank_htu_opcode_i != 2'b00), xbar_bank_htu_ch_id_i,
                     seq_q[xbar_bank_htu_ch_id_i], xbar_bank_htu_addr_i,
                     xbar_bank_htu_wbuffer_id_i};
  assign head_s   = req_mem_q[req_rp_q];
  // Outstanding reads = in the array pipe plus parked in the return FIFO.
  assign credit_s = ({1'b0, inflight_q} + {1'b0, rtn_cnt_q}) < (TCW+1)'(RTN_DEPTH);

  // Issue selection: FIFO head in order, or the incoming request when bypass is built in.
  always_comb begin
    iss_s     = head_s;
    iss_vld_s = 1'b0;
    bypass_s  = 1'b0;
    if (req_cnt_q != '0) begin
      iss_s     = head_s;
      iss_vld_s = head_s.wr || credit_s;
    end
`ifdef BANK_XBAR_RESP_BYPASS_EN
    else if (accept_s && (in_req_s.wr || credit_s)) begin
      iss_s     = in_req_s;
      iss_vld_s = 1'b1;
      bypass_s  = 1'b1;
    end
`endif
    else begin
      iss_s     = head_s;
      iss_vld_s = 1'b0;
    end
  end

  assign pop_s       = iss_vld_s && !bypass_s;
  assign push_s      = accept_s && !bypass_s;
  assign rd_iss_s    = iss_vld_s && !iss_s.wr;
  assign wr_iss_s    = iss_vld_s && iss_s.wr;
  assign pipe_last_s = pipe_vld_q[RD_LAT-1];
  assign rtn_vld_s   = (rtn_cnt_q != '0);
  assign rtn_pop_s   = rtn_vld_s && bank_sc_xbar_allowIn_i;
  assign rtn_head_s  = rtn_mem_q[rtn_rp_q];

  assign req_cnt_d  = req_cnt_q + RCW'(push_s) - RCW'(pop_s);
  assign inflight_d = inflight_q + TCW'(rd_iss_s) - TCW'(pipe_last_s);
  assign rtn_cnt_d  = rtn_cnt_q + TCW'(pipe_last_s) - TCW'(rtn_pop_s);

  assign xbar_bank_htu_allowIn_o = allow_q;
  assign arr_rd_valid_o          = rd_iss_s;
  assign arr_rd_addr_o           = rd_iss_s ? iss_s.addr : 28'd0;
  assign arr_wr_valid_o          = wr_iss_s;
  assign arr_wr_addr_o           = wr_iss_s ? iss_s.addr : 28'd0;
  assign arr_wr_wbuffer_id_o     = wr_iss_s ? iss_s.wbid : 8'd0;
  assign bank_sc_xbar_valid_o    = rtn_vld_s;
  assign bank_sc_xbar_ch_id_o    = rtn_vld_s ? rtn_head_s.ch : 2'd0;
  assign bank_sc_xbar_rob_num_o  = rtn_vld_s ? rtn_head_s.rob : 3'd0;
  assign bank_sc_xbar_data_o     = rtn_vld_s ? rtn_head_s.data : 128'd0;

  // Control state: pointers, counters, sequence numbers, pipe valids.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_wp_q   <= '0;
      req_rp_q   <= '0;
      req_cnt_q  <= '0;
      allow_q    <= 1'b0;
      inflight_q <= '0;
      pipe_vld_q <= '0;
      rtn_wp_q   <= '0;
      rtn_rp_q   <= '0;
      rtn_cnt_q  <= '0;
      for (int c = 0; c < 4; c++) seq_q[c] <= 3'd0;
    end else begin
      if (push_s) req_wp_q <= req_wp_q + RAW'(1);
      if (pop_s)  req_rp_q <= req_rp_q + RAW'(1);
      req_cnt_q  <= req_cnt_d;
      allow_q    <= (req_cnt_d < RCW'(REQ_DEPTH));
      inflight_q <= inflight_d;
      pipe_vld_q[0] <= rd_iss_s;
      for (int i = 1; i < RD_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      if (pipe_last_s) rtn_wp_q <= rtn_wp_q + TAW'(1);
      if (rtn_pop_s)   rtn_rp_q <= rtn_rp_q + TAW'(1);
      rtn_cnt_q <= rtn_cnt_d;
      if (accept_s && !in_req_s.wr)
        seq_q[xbar_bank_htu_ch_id_i] <= seq_q[xbar_bank_htu_ch_id_i] + 3'd1;
    end
  end

  // Storage without reset; contents are qualified by the counters and pipe valids.
  always_ff @(posedge clk_i) begin
    if (push_s) req_mem_q[req_wp_q] <= in_req_s;
    pipe_ch_q[0]  <= iss_s.ch;
    pipe_rob_q[0] <= iss_s.rob;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_ch_q[i]  <= pipe_ch_q[i-1];
      pipe_rob_q[i] <= pipe_rob_q[i-1];
    end
    if (pipe_last_s)
      rtn_mem_q[rtn_wp_q] <= {pipe_ch_q[RD_LAT-1], pipe_rob_q[RD_LAT-1], arr_rd_data_i};
  end

endmodule

// File: tb/tb_bank_xbar_resp.sv
// tb_bank_xbar_resp: directed and random traffic against a transaction-level model of bank_xbar_resp.
module tb_bank_xbar_resp;
  localparam int RD_LAT    = 2;
  localparam int REQ_DEPTH = 4;
  localparam int RTN_DEPTH = 4;
`ifdef BANK_XBAR_RESP_BYPASS_EN
  localparam int EXP_RD_K = 0;
  localparam int EXP_RT_K = 1 + RD_LAT;
`else
  localparam int EXP_RD_K = 1;
  localparam int EXP_RT_K = 2 + RD_LAT;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         allow_o;
  logic [1:0]   ch_i;
  logic [1:0]   op_i;
  logic [27:0]  addr_i;
  logic [7:0]   wbid_i;
  logic         rd_v;
  logic [27:0]  rd_addr;
  logic [127:0] rd_data;
  logic         wr_v;
  logic [27:0]  wr_addr;
  logic [7:0]   wr_wbid;
  logic         rt_v;
  logic         rt_allow;
  logic [1:0]   rt_ch;
  logic [2:0]   rt_rob;
  logic [127:0] rt_data;

  bank_xbar_resp #(.REQ_DEPTH(REQ_DEPTH), .RTN_DEPTH(RTN_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .xbar_bank_htu_valid_i(valid_i), .xbar_bank_htu_allowIn_o(allow_o),
    .xbar_bank_htu_ch_id_i(ch_i), .xbar_bank_htu_opcode_i(op_i),
    .xbar_bank_htu_addr_i(addr_i), .xbar_bank_htu_wbuffer_id_i(wbid_i),
    .arr_rd_valid_o(rd_v), .arr_rd_addr_o(rd_addr), .arr_rd_data_i(rd_data),
    .arr_wr_valid_o(wr_v), .arr_wr_addr_o(wr_addr), .arr_wr_wbuffer_id_o(wr_wbid),
    .bank_sc_xbar_valid_o(rt_v), .bank_sc_xbar_allowIn_i(rt_allow),
    .bank_sc_xbar_ch_id_o(rt_ch), .bank_sc_xbar_rob_num_o(rt_rob),
    .bank_sc_xbar_data_o(rt_data)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit wr; bit [1:0] ch; bit [2:0] rob; bit [27:0] addr; bit [7:0] wbid; } ent_t;
  typedef struct { bit [1:0] ch; bit [2:0] rob; bit [127:0] data; } rtn_t;
  typedef struct { int due; bit [27:0] addr; } sch_t;

  ent_t order_q[$];
  rtn_t exp_q[$];
  sch_t sched_q[$];
  bit [2:0] m_seq [4];
  int  m_occ, m_out, cyc;
  bit  prev_rst;
  int  n_chk, n_fail;
  int  n_rd, n_wr, n_rt;
  bit [2:0] last_rob;
  bit [1:0] last_ch;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [127:0] data_of(input logic [27:0] a);
    return {a, 4'h1, ~a, 4'h2, a ^ 28'h5a5a5a5, 4'h3, a + 28'd77, 4'h4};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model: request order, per-channel sequence, occupancy and read credit.
  always @(negedge clk_i) begin
    bit acc, exp_stb, got_stb, found;
    ent_t e;
    rtn_t r;
    logic [127:0] drv;
    if (rst_i) begin
      order_q.delete();
      exp_q.delete();
      for (int c = 0; c < 4; c++) m_seq[c] = 3'd0;
      m_occ = 0;
      m_out = 0;
      prev_rst = 1'b1;
    end else begin
      check("allowIn", allow_o, !prev_rst && (m_occ < REQ_DEPTH));
      acc = valid_i && allow_o;
      if (acc) begin
        e.wr = (op_i != 2'b00); e.ch = ch_i; e.addr = addr_i; e.wbid = wbid_i;
        e.rob = e.wr ? 3'd0 : m_seq[ch_i];
        if (!e.wr) m_seq[ch_i] = m_seq[ch_i] + 3'd1;
        order_q.push_back(e);
      end
      exp_stb = 1'b0;
      if (m_occ > 0) exp_stb = order_q[0].wr || (m_out < RTN_DEPTH);
`ifdef BANK_XBAR_RESP_BYPASS_EN
      else if (acc) exp_stb = order_q[0].wr || (m_out < RTN_DEPTH);
`endif
      got_stb = rd_v || wr_v;
      check("strobe", got_stb, exp_stb);
      if (got_stb) begin
        check("one_strobe", rd_v && wr_v, 1'b0);
        if (order_q.size() == 0) check("stb_no_req", 1'b1, 1'b0);
        else begin
          e = order_q.pop_front();
          check("stb_kind", wr_v, e.wr);
          if (wr_v) begin
            check("wr_addr", wr_addr, e.addr);
            check("wr_wbid", wr_wbid, e.wbid);
            n_wr++;
          end else begin
            check("rd_addr", rd_addr, e.addr);
            r.ch = e.ch; r.rob = e.rob; r.data = data_of(e.addr);
            exp_q.push_back(r);
            sched_q.push_back('{cyc + RD_LAT, rd_addr});
            m_out++;
            check("credit", m_out <= RTN_DEPTH, 1'b1);
            n_rd++;
          end
        end
        if (m_occ > 0) m_occ--;
      end
      if (acc) m_occ++;
      if (acc && got_stb && m_occ > 0 && order_q.size() < m_occ) m_occ = order_q.size();
      check("rtn_spurious", rt_v && (exp_q.size() == 0), 1'b0);
      if (rt_v && rt_allow && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("rtn_ch", rt_ch, r.ch);
        check("rtn_rob", rt_rob, r.rob);
        check("rtn_data", rt_data, r.data);
        last_rob = rt_rob;
        last_ch  = rt_ch;
        m_out--;
        n_rt++;
      end
      prev_rst = 1'b0;
    end
    // Array model: data appears RD_LAT cycles after the strobe, garbage otherwise.
    found = 1'b0;
    drv = {$urandom, $urandom, $urandom, $urandom};
    foreach (sched_q[i]) if (sched_q[i].due == cyc) begin drv = data_of(sched_q[i].addr); found = 1'b1; end
    while (sched_q.size() > 0 && sched_q[0].due <= cyc) void'(sched_q.pop_front());
    rd_data = drv;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [27:0] a, input logic [7:0] wb);
    bit done;
    done = 1'b0;
    valid_i = 1'b1; op_i = op; ch_i = ch; addr_i = a; wbid_i = wb;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      done = allow_o;
      step();
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int left;
    valid_i = 1'b0;
    rt_allow = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      left = order_q.size() + exp_q.size();
      if (left == 0 && !rt_v) break;
    end
    check("drain_empty", left, 0);
    step();
  endtask

  initial begin
    int rd_k, rt_k, b_rd, b_wr, b_rt;
    logic [1:0] cap_ch;
    logic [2:0] cap_rob;
    logic [127:0] cap_data;
    cyc = 0; n_chk = 0; n_fail = 0; n_rd = 0; n_wr = 0; n_rt = 0;
    rst_i = 1'b1; valid_i = 1'b0; ch_i = 2'd0; op_i = 2'd0; addr_i = 28'd0; wbid_i = 8'd0;
    rt_allow = 1'b1; rd_data = 128'd0;
    step();
    @(negedge clk_i);
    check("rst_allow", allow_o, 1'b0);
    check("rst_rd_v", rd_v, 1'b0);
    check("rst_wr_v", wr_v, 1'b0);
    check("rst_rt_v", rt_v, 1'b0);
    step();
    rst_i = 1'b0;
    step(); step();

    // Single read latency on ch1.
    rd_k = -1; rt_k = -1; cap_ch = 2'd0; cap_rob = 3'd7; cap_data = 128'd0;
    valid_i = 1'b1; op_i = 2'b00; ch_i = 2'd1; addr_i = 28'h0000100; wbid_i = 8'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_i);
      if (rd_v && rd_k < 0) rd_k = k;
      if (rt_v && rt_k < 0) begin rt_k = k; cap_ch = rt_ch; cap_rob = rt_rob; cap_data = rt_data; end
      step();
      valid_i = 1'b0;
    end
    check("lat_rd", rd_k, EXP_RD_K);
    check("lat_rtn", rt_k, EXP_RT_K);
    check("lat_ch", cap_ch, 2'd1);
    check("lat_rob", cap_rob, 3'd0);
    check("lat_data", cap_data, data_of(28'h0000100));
    drain();

    // Nine ch2 reads interleaved with ch0 writes; rob wraps 7 -> 0.
    b_wr = n_wr; b_rt = n_rt;
    for (int i = 0; i < 9; i++) begin
      send(2'b00, 2'd2, 28'h200 + 28'(i), 8'd0);
      send(2'b01 + 2'(i % 3), 2'd0, 28'h300 + 28'(i), 8'(8'h40 + i));
    end
    drain();
    check("ilv_wr_count", n_wr - b_wr, 9);
    check("ilv_rtn_count", n_rt - b_rt, 9);
    check("ilv_last_rob", last_rob, 3'd0);

    // Return path blocked: credit caps issue at RTN_DEPTH, then request FIFO fills.
    rt_allow = 1'b0; b_rd = n_rd; b_rt = n_rt;
    for (int i = 0; i < 8; i++) send(2'b00, 2'(i % 4), 28'h400 + 28'(i), 8'd0);
    valid_i = 1'b0;
    repeat (10) step();
    @(negedge clk_i);
    check("blk_rd_count", n_rd - b_rd, RTN_DEPTH);
    check("blk_allow", allow_o, 1'b0);
    step();
    drain();
    check("blk_rtn_count", n_rt - b_rt, 8);

    // Write behind a credit-stalled read must wait.
    rt_allow = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b00, 2'd3, 28'h500 + 28'(i), 8'd0);
    b_wr = n_wr;
    send(2'b00, 2'd3, 28'h510, 8'd0);
    send(2'b10, 2'd1, 28'h520, 8'h77);
    valid_i = 1'b0;
    repeat (10) step();
    check("stall_wr_count", n_wr - b_wr, 0);
    drain();
    check("stall_wr_after", n_wr - b_wr, 1);

    // Reset with reads in flight and returns pending.
    rt_allow = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b00, 2'd0, 28'h600 + 28'(i), 8'd0);
    valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mrst_rd_v", rd_v, 1'b0);
    check("mrst_wr_v", wr_v, 1'b0);
    check("mrst_rt_v", rt_v, 1'b0);
    check("mrst_allow", allow_o, 1'b0);
    step();
    rt_allow = 1'b1;
    repeat (10) step();
    send(2'b00, 2'd0, 28'h700, 8'd0);
    drain();
    check("mrst_rob_ch", last_ch, 2'd0);
    check("mrst_rob", last_rob, 3'd0);

    // Random traffic with random backpressure and one reset.
    for (int i = 0; i < 600; i++) begin
      valid_i  = ($urandom % 3) != 0;
      op_i     = 2'($urandom % 4 == 0 ? $urandom : 0);
      ch_i     = 2'($urandom);
      addr_i   = 28'($urandom);
      wbid_i   = 8'($urandom);
      rt_allow = ($urandom % 4) != 0;
      rst_i    = (i == 300);
      step();
    end
    rst_i = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bank_xbar_resp.md
Name: bank_xbar_resp

Overview:
- Bank-side endpoint of the crossbar request/return protocol; one instance per cache bank.
- Accepts the xbar-to-bank HTU request stream and buffers it in order.
- Issues reads and writes to the bank data array.
- Returns read data to the crossbar reorder buffer over the bank sc-to-xbar interface, stamping each return with channel id and a per-channel sequence number (rob_num).

Parameters:
- REQ_DEPTH, 4: request FIFO entries (power of 2, ≥2).
- RTN_DEPTH, 4: return FIFO entries; also the read-credit limit (power of 2, ≥2).
- RD_LAT, 2: data-array read latency in cycles (≥1).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
xbar_bank_htu_valid_i  in  1  request valid
xbar_bank_htu_allowIn_o  out  1  request accept (ready)
xbar_bank_htu_ch_id_i  in  2  requesting channel
xbar_bank_htu_opcode_i  in  2  00=read, others=write
xbar_bank_htu_addr_i  in  28  line address [31:4]
xbar_bank_htu_wbuffer_id_i  in  8  write-buffer entry id
arr_rd_valid_o  out  1  array read strobe
arr_rd_addr_o  out  28  array read address
arr_rd_data_i  in  128  read data, valid RD_LAT cycles after strobe
arr_wr_valid_o  out  1  array write strobe; array always accepts
arr_wr_addr_o  out  28  array write address
arr_wr_wbuffer_id_o  out  8  write-buffer id for data fetch
bank_sc_xbar_valid_o  out  1  return valid
bank_sc_xbar_allowIn_i  in  1  return accept from rob
bank_sc_xbar_ch_id_o  out  2  return channel
bank_sc_xbar_rob_num_o  out  3  per-channel sequence number
bank_sc_xbar_data_o  out  128  read data

Behaviour:
- Reset: all FIFOs, pipeline stages and counters cleared. All outputs are 0 while rst_i is high, including allowIn_o. allowIn_o rises the first cycle after rst_i falls. Reset mid-operation discards queued requests, in-flight reads and pending returns; array data arriving after reset is ignored.
- Accept: a request is taken when valid_i && allowIn_o.
  - allowIn_o = (req_count < REQ_DEPTH), from registered count only; a same-cycle pop does not free a slot.
  - Reads: stamped at accept with rob_num = seq[ch_id]; seq[ch_id] then increments mod 8 (7 wraps to 0). Four independent 3-bit counters, one per ch_id value, including 3.
  - Writes do not consume a sequence number.
- Issue: FIFO head only, strictly in order, at most one request per cycle.
  - Head write: issues unconditionally. arr_wr_valid_o=1 with addr and wbuffer_id for one cycle, then pop. No return is generated.
  - Head read: issues only when inflight + rtn_count < RTN_DEPTH (both registered). arr_rd_valid_o=1 for one cycle, then pop. If credit is exhausted the head stalls, which also blocks writes behind it.
- Read pipe: an RD_LAT-stage shift register carries {valid, ch_id, rob_num}. At the final stage arr_rd_data_i is captured with the tag into the return FIFO.
- Return: FIFO head drives valid/ch_id/rob_num/data. Pop on valid_o && allowIn_i. Outputs hold stable while allowIn_i is low. Push and pop in the same cycle are allowed.
- Latency (no macro): accept at cycle T, earliest arr_rd_valid_o at T+1, earliest bank_sc_xbar_valid_o at T+2+RD_LAT. A write's earliest strobe is at T+1.
- Full/empty:
  - The credit rule guarantees the return FIFO never overflows.
  - When the request FIFO is full, allowIn_o=0 until the cycle after a pop.
  - When both FIFOs are empty and nothing is in flight, all valids are 0.

Optional Feature:
- Macro BANK_XBAR_RESP_BYPASS_EN.
- Defined: when the request FIFO is empty and the incoming request can issue (a write, or a read with credit), it goes to the array in the accept cycle T without being enqueued. Earliest return is at T+1+RD_LAT; earliest write strobe is at T. Sequence stamping is unchanged.
- Undefined: every request is enqueued, with the latencies stated above.

Test Plan:
- Single read ch1 addr 0x0000100, RD_LAT=2, allowIn_i=1, no macro: accept T → arr_rd_valid_o at T+1 → return valid at T+4, ch_id=1, rob_num=0, data = array word.
- Nine reads on ch2 interleaved with writes on ch0: rob_num sequence 0..7,0 on ch2. Writes pulse arr_wr_valid_o with matching wbuffer_id and produce no return.
- Hold allowIn_i=0 and send 8 reads: exactly 4 arr_rd_valid_o pulses, then allowIn_o=0 once the request FIFO holds 4. Release allowIn_i: all 8 returns arrive in order, none lost.
- Read stalled for credit followed by a write: the write's strobe does not occur before the read's strobe.
- Assert rst_i for one cycle while 2 reads are in flight and 2 returns are pending: all valids are 0 the following cycle, no stale return ever appears, and ch0 rob_num restarts at 0.
- With BANK_XBAR_RESP_BYPASS_EN and an idle block: a read accepted at T gives arr_rd_valid_o at T and return valid at T+3 (RD_LAT=2).
